// File: rtl/cpu_step_controller_pkg.sv
// Shared constants for the CPU step controller: state encoding,
// the self-jump opcode and the rate-select width.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [3:0] OPC_JMP    = 4'hF;
    localparam int         RATE_SEL_W = 2;

    function automatic int max4(input int a, input int b,
                                input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/cpu_step_controller_if.sv
// Board/datapath bundle for the step controller.
// master: board and datapath side (drives key, switches, PC, INSTR).
// slave : controller side (drives CPU_EN, STATE, HALTED, CYCLE_CNT).
// With CPU_STEP_BREAKPOINT_EN defined, BP_ADDR/BP_VALID are added.
interface cpu_step_controller_if;
    import cpu_ctrl_pkg::*;

    logic                  STEP_KEY_N;
    logic                  RUN_SW;
    logic [RATE_SEL_W-1:0] RATE_SEL;
    logic [3:0]            PC;
    logic [7:0]            INSTR;
    logic                  CPU_EN;
    logic [1:0]            STATE;
    logic                  HALTED;
    logic [7:0]            CYCLE_CNT;
`ifdef CPU_STEP_BREAKPOINT_EN
    logic [3:0]            BP_ADDR;
    logic                  BP_VALID;

    modport master (
        output STEP_KEY_N, RUN_SW, RATE_SEL, PC, INSTR,
        output BP_ADDR, BP_VALID,
        input  CPU_EN, STATE, HALTED, CYCLE_CNT
    );
    modport slave (
        input  STEP_KEY_N, RUN_SW, RATE_SEL, PC, INSTR,
        input  BP_ADDR, BP_VALID,
        output CPU_EN, STATE, HALTED, CYCLE_CNT
    );
`else
    modport master (
        output STEP_KEY_N, RUN_SW, RATE_SEL, PC, INSTR,
        input  CPU_EN, STATE, HALTED, CYCLE_CNT
    );
    modport slave (
        input  STEP_KEY_N, RUN_SW, RATE_SEL, PC, INSTR,
        output CPU_EN, STATE, HALTED, CYCLE_CNT
    );
`endif

endinterface

// File: rtl/cpu_step_controller_key_debouncer.sv
// Step-key conditioner: 2-FF synchronizer, stability counter and
// one-cycle press pulse on a debounced 1->0 transition.
// Ports: clk_i, rst_i (sync, active-high), key_n_i (raw, active-low),
//        press_o (one-cycle pulse per accepted press).
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_n_i,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 :
                        $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          differ;
    logic          accept;

    // Accept the new level on the Nth consecutive differing sample.
    assign differ = (sync2_q != level_q);
    assign accept = differ && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        if (differ && !accept) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            press_q <= accept && !sync2_q;
            if (accept) begin
                level_q <= sync2_q;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/cpu_step_controller.sv
// Sequencing controller producing the one-cycle datapath enable CPU_EN
// (free-run at a selectable rate, single-step on key, halt on self-jump).
// Ports: CLOCK_50, RESET (sync, active-high), bus (slave modport:
//        STEP_KEY_N, RUN_SW, RATE_SEL, PC, INSTR in; CPU_EN, STATE,
//        HALTED, CYCLE_CNT out). Optional macro CPU_STEP_BREAKPOINT_EN
//        adds BP_ADDR/BP_VALID and the run-mode breakpoint.
module cpu_step_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RATE_DIV_0      = 50000000,
    parameter int RATE_DIV_1      = 5000000,
    parameter int RATE_DIV_2      = 500000,
    parameter int RATE_DIV_3      = 1
) (
    input logic                 CLOCK_50,
    input logic                 RESET,
    cpu_step_controller_if.slave bus
);
    import cpu_ctrl_pkg::*;

    localparam int DIV_MAX = max4(RATE_DIV_0, RATE_DIV_1,
                                  RATE_DIV_2, RATE_DIV_3);
    localparam int PW      = (DIV_MAX <= 1) ? 1 : $clog2(DIV_MAX);

    localparam logic [PW-1:0] TC0 = PW'(RATE_DIV_0 - 1);
    localparam logic [PW-1:0] TC1 = PW'(RATE_DIV_1 - 1);
    localparam logic [PW-1:0] TC2 = PW'(RATE_DIV_2 - 1);
    localparam logic [PW-1:0] TC3 = PW'(RATE_DIV_3 - 1);

    state_t                state_q;
    logic                  cpu_en_q;
    logic                  halted_q;
    logic [7:0]            cnt_q;
    logic [7:0]            cnt_d;
    logic [PW-1:0]         presc_q;
    logic [RATE_SEL_W-1:0] rate_sel_q;

    logic          step;
    logic          halt_hit;
    logic          rate_chg;
    logic          tc;
    logic [PW-1:0] tc_val;
    logic          bp_hit;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .clk_i  (CLOCK_50),
        .rst_i  (RESET),
        .key_n_i(bus.STEP_KEY_N),
        .press_o(step)
    );

    assign halt_hit = (bus.INSTR[7:4] == OPC_JMP) &&
                      (bus.INSTR[3:0] == bus.PC);

    // Rate change is detected against last cycle's select.
    assign rate_chg = (bus.RATE_SEL != rate_sel_q);

`ifdef CPU_STEP_BREAKPOINT_EN
    assign bp_hit = bus.BP_VALID && (bus.PC == bus.BP_ADDR);
`else
    assign bp_hit = 1'b0;
`endif

    always_comb begin
        tc_val = TC0;
        unique case (rate_sel_q)
            2'd0: tc_val = TC0;
            2'd1: tc_val = TC1;
            2'd2: tc_val = TC2;
            2'd3: tc_val = TC3;
            default: tc_val = TC0;
        endcase
    end

    assign tc = (presc_q == tc_val);

    always_comb begin
        cnt_d = cnt_q;
        if (cpu_en_q && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            cpu_en_q   <= 1'b0;
            halted_q   <= 1'b0;
            cnt_q      <= 8'h00;
            presc_q    <= '0;
            rate_sel_q <= '0;
        end else begin
            cpu_en_q   <= 1'b0;
            rate_sel_q <= bus.RATE_SEL;
            cnt_q      <= cnt_d;
            unique case (state_q)
                ST_IDLE: begin
                    presc_q <= '0;
                    // RUN_SW wins over a same-cycle step event.
                    if (bus.RUN_SW) begin
                        state_q <= ST_RUN;
                    end else if (step) begin
                        if (halt_hit) begin
                            state_q  <= ST_HALT;
                            halted_q <= 1'b1;
                        end else begin
                            cpu_en_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (!bus.RUN_SW) begin
                        state_q <= ST_IDLE;
                        presc_q <= '0;
                    end else if (rate_chg) begin
                        presc_q <= '0;
                    end else if (tc) begin
                        presc_q <= '0;
                        if (halt_hit) begin
                            state_q  <= ST_HALT;
                            halted_q <= 1'b1;
                        end else if (bp_hit) begin
                            // PC stays put; next step runs it.
                            state_q <= ST_IDLE;
                        end else begin
                            cpu_en_q <= 1'b1;
                        end
                    end else begin
                        presc_q <= presc_q + 1'b1;
                    end
                end
                ST_HALT: begin
                    state_q  <= ST_HALT;
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.CPU_EN    = cpu_en_q;
    assign bus.STATE     = state_q;
    assign bus.HALTED    = halted_q;
    assign bus.CYCLE_CNT = cnt_q;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Directed testbench for cpu_step_controller (small debounce/rate
// parameters); define CPU_STEP_BREAKPOINT_EN to add the breakpoint test.
module tb_cpu_step_controller;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   en_cnt;

    cpu_step_controller_if bus ();

    cpu_step_controller #(
        .DEBOUNCE_CYCLES(4),
        .RATE_DIV_0     (8),
        .RATE_DIV_1     (4),
        .RATE_DIV_2     (2),
        .RATE_DIV_3     (1)
    ) dut (
        .CLOCK_50(clk),
        .RESET   (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts CPU_EN cycles; each posedge sees the level of the cycle ending.
    always @(posedge clk) begin
        if (bus.CPU_EN === 1'b1) en_cnt <= en_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic press(input int low_cycles, input int high_cycles);
        bus.STEP_KEY_N = 1'b0;
        tick(low_cycles);
        bus.STEP_KEY_N = 1'b1;
        tick(high_cycles);
    endtask

    task automatic test_reset();
        bus.RUN_SW = 1'b1;
        rst = 1'b1;
        tick(2);
        tests++;
        if (bus.STATE !== 2'd0) begin
            fails++;
            $display("FAIL reset_state got %0d want 0", bus.STATE);
        end
        tests++;
        if (bus.CPU_EN !== 1'b0) begin
            fails++;
            $display("FAIL reset_cpu_en got %b want 0", bus.CPU_EN);
        end
        tests++;
        if (bus.CYCLE_CNT !== 8'h00) begin
            fails++;
            $display("FAIL reset_cnt got %h want 00", bus.CYCLE_CNT);
        end
        tests++;
        if (bus.HALTED !== 1'b0) begin
            fails++;
            $display("FAIL reset_halted got %b want 0", bus.HALTED);
        end
        rst = 1'b0;
        tick(1);
        tests++;
        if (bus.STATE !== 2'd1) begin
            fails++;
            $display("FAIL reset_run_entry got %0d want 1", bus.STATE);
        end
        bus.RUN_SW = 1'b0;
        tick(1);
    endtask

    task automatic test_debounce();
        int base;
        bus.RUN_SW = 1'b0;
        bus.RATE_SEL = 2'd0;
        bus.PC = 4'h0;
        bus.INSTR = 8'h00;
        do_reset();
        base = en_cnt;
        press(3, 12);
        tests++;
        if (en_cnt - base !== 0) begin
            fails++;
            $display("FAIL debounce_bounce pulses %0d want 0", en_cnt - base);
        end
        bus.STEP_KEY_N = 1'b0;
        tick(6);
        bus.STEP_KEY_N = 1'b1;
        tick(3);
        tests++;
        if (en_cnt - base !== 1) begin
            fails++;
            $display("FAIL debounce_press pulses %0d want 1", en_cnt - base);
        end
        tick(15);
        tests++;
        if (en_cnt - base !== 1) begin
            fails++;
            $display("FAIL debounce_release pulses %0d want 1", en_cnt - base);
        end
        tests++;
        if (bus.CYCLE_CNT !== 8'h01) begin
            fails++;
            $display("FAIL debounce_cnt got %h want 01", bus.CYCLE_CNT);
        end
        tests++;
        if (bus.STATE !== 2'd0) begin
            fails++;
            $display("FAIL debounce_state got %0d want 0", bus.STATE);
        end
    endtask

    task automatic test_run_rate();
        int base;
        int low;
        bus.RATE_SEL = 2'd0;
        bus.RUN_SW = 1'b1;
        tick(1);
        base = en_cnt;
        tick(41);
        tests++;
        if (en_cnt - base !== 5) begin
            fails++;
            $display("FAIL rate_div8 pulses %0d want 5", en_cnt - base);
        end
        bus.RATE_SEL = 2'd3;
        tick(2);
        low = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.CPU_EN !== 1'b1) low++;
            tick(1);
        end
        tests++;
        if (low !== 0) begin
            fails++;
            $display("FAIL rate_full low_cycles %0d want 0", low);
        end
        bus.RUN_SW = 1'b0;
        tick(1);
        tests++;
        if (bus.CPU_EN !== 1'b0) begin
            fails++;
            $display("FAIL run_stop_en got %b want 0", bus.CPU_EN);
        end
        tests++;
        if (bus.STATE !== 2'd0) begin
            fails++;
            $display("FAIL run_stop_state got %0d want 0", bus.STATE);
        end
    endtask

    task automatic test_halt();
        int base;
        bus.RATE_SEL = 2'd1;
        bus.PC = 4'h6;
        bus.INSTR = 8'hF6;
        tick(1);
        base = en_cnt;
        bus.RUN_SW = 1'b1;
        tick(10);
        tests++;
        if (bus.STATE !== 2'd2 || bus.HALTED !== 1'b1) begin
            fails++;
            $display("FAIL halt_enter state %0d halted %b want 2 1",
                     bus.STATE, bus.HALTED);
        end
        tests++;
        if (en_cnt - base !== 0) begin
            fails++;
            $display("FAIL halt_no_pulse pulses %0d want 0", en_cnt - base);
        end
        bus.INSTR = 8'h00;
        bus.RUN_SW = 1'b0;
        tick(2);
        bus.RUN_SW = 1'b1;
        tick(2);
        bus.RUN_SW = 1'b0;
        press(6, 12);
        tests++;
        if (bus.STATE !== 2'd2 || en_cnt - base !== 0) begin
            fails++;
            $display("FAIL halt_sticky state %0d pulses %0d want 2 0",
                     bus.STATE, en_cnt - base);
        end
        do_reset();
        tests++;
        if (bus.STATE !== 2'd0 || bus.HALTED !== 1'b0) begin
            fails++;
            $display("FAIL halt_reset state %0d halted %b want 0 0",
                     bus.STATE, bus.HALTED);
        end
    endtask

    task automatic test_saturation();
        bus.INSTR = 8'h00;
        bus.RATE_SEL = 2'd3;
        bus.RUN_SW = 1'b1;
        tick(300);
        tests++;
        if (bus.CYCLE_CNT !== 8'hFF) begin
            fails++;
            $display("FAIL sat_reach got %h want ff", bus.CYCLE_CNT);
        end
        tick(20);
        tests++;
        if (bus.CYCLE_CNT !== 8'hFF || bus.CPU_EN !== 1'b1) begin
            fails++;
            $display("FAIL sat_hold cnt %h en %b want ff 1",
                     bus.CYCLE_CNT, bus.CPU_EN);
        end
        bus.RUN_SW = 1'b0;
        tick(2);
    endtask

`ifdef CPU_STEP_BREAKPOINT_EN
    task automatic test_breakpoint();
        int  base;
        bit  hit;
        bus.RUN_SW = 1'b0;
        bus.INSTR = 8'h00;
        bus.PC = 4'h3;
        bus.BP_ADDR = 4'h3;
        bus.BP_VALID = 1'b1;
        bus.RATE_SEL = 2'd2;
        do_reset();
        tick(1);
        base = en_cnt;
        bus.RUN_SW = 1'b1;
        tick(1);
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.STATE === 2'd0) begin
                hit = 1'b1;
                break;
            end
        end
        bus.RUN_SW = 1'b0;
        tests++;
        if (!hit || en_cnt - base !== 0) begin
            fails++;
            $display("FAIL bp_stop hit %b pulses %0d want 1 0",
                     hit, en_cnt - base);
        end
        tick(2);
        press(6, 12);
        tests++;
        if (en_cnt - base !== 1 || bus.STATE !== 2'd0) begin
            fails++;
            $display("FAIL bp_step pulses %0d state %0d want 1 0",
                     en_cnt - base, bus.STATE);
        end
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        en_cnt = 0;
        rst = 1'b1;
        bus.STEP_KEY_N = 1'b1;
        bus.RUN_SW = 1'b0;
        bus.RATE_SEL = 2'd0;
        bus.PC = 4'h0;
        bus.INSTR = 8'h00;
`ifdef CPU_STEP_BREAKPOINT_EN
        bus.BP_ADDR = 4'h0;
        bus.BP_VALID = 1'b0;
`endif
        tick(1);
        test_reset();
        test_debounce();
        test_run_rate();
        test_halt();
        test_saturation();
`ifdef CPU_STEP_BREAKPOINT_EN
        test_breakpoint();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_step_controller.md
Name: cpu_step_controller

Overview:
- Sequencing controller for the 4-bit CPU datapath (RegA/RegB/output register, PC counter, carry DFF).
- Produces a one-cycle clock-enable CPU_EN, so the datapath advances at a selectable rate, single-steps on a debounced key, or stops on a self-jump halt.
- Datapath registers load only when CPU_EN=1; no gated clocks. Sits between the board I/O (KEY/SW) and the datapath enables.

Parameters:
DEBOUNCE_CYCLES, 500000, number of consecutive stable cycles (10 ms at 50 MHz) before a key level is accepted
RATE_DIV_0, 50000000, CLOCK_50 cycles per instruction when RATE_SEL=0 (1 Hz)
RATE_DIV_1, 5000000, cycles per instruction when RATE_SEL=1 (10 Hz)
RATE_DIV_2, 500000, cycles per instruction when RATE_SEL=2 (100 Hz)
RATE_DIV_3, 1, cycles per instruction when RATE_SEL=3 (full speed)

Ports:
CLOCK_50  in  1  system clock; the only clock
RESET  in  1  synchronous, active-high reset (top level drives it from ~KEY[0])
STEP_KEY_N  in  1  raw asynchronous step key, active-low (KEY[1])
RUN_SW  in  1  1=free-run mode, 0=single-step mode
RATE_SEL  in  2  run-rate select, indexes RATE_DIV_0..3
PC  in  4  current ROM address from the PC counter
INSTR  in  8  ROM data at PC; opcode in [7:4], immediate in [3:0]
CPU_EN  out  1  one-cycle datapath advance strobe
STATE  out  2  0=IDLE, 1=RUN, 2=HALT
HALTED  out  1  1 while STATE=HALT
CYCLE_CNT  out  8  count of CPU_EN pulses issued, saturating

Behaviour:
- Reset (synchronous, active-high, priority over all other events):
  - STATE=IDLE; CPU_EN=0; HALTED=0; CYCLE_CNT=0.
  - Prescaler, debounce counter and debounced level (released=1) cleared.
  - Asserting reset mid-run aborts with no pulse in that cycle.
- Key input:
  - STEP_KEY_N passes through a 2-FF synchronizer.
  - Debounced level updates only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
  - A step event is a one-cycle pulse on a debounced 1->0 transition (press). Release produces no event.
- Self-jump detect: halt_hit = (INSTR[7:4]==4'hF) && (INSTR[3:0]==PC).
- IDLE:
  - If RUN_SW=1, go to RUN; prescaler cleared.
  - Else on a step event: if halt_hit, go to HALT with no pulse; otherwise CPU_EN=1 in the cycle after the event cycle.
  - Step event and RUN_SW rising in the same cycle: RUN wins, step discarded.
- RUN:
  - Prescaler counts 0..RATE_DIV[RATE_SEL]-1 and wraps.
  - At terminal count: if halt_hit, go to HALT with no pulse; else CPU_EN=1 for that cycle.
  - RATE_DIV=1 gives CPU_EN high every cycle.
  - A RATE_SEL change (registered compare) clears the prescaler with no pulse that cycle.
  - RUN_SW=0 returns to IDLE, clears the prescaler, no pulse that cycle; RUN_SW takes priority over terminal count.
  - Step events ignored.
- HALT: sticky. CPU_EN=0; step events and RUN_SW ignored; exit only via RESET.
- CPU_EN is a registered output, never high two cycles in a row except when RATE_DIV=1 in RUN.
- CYCLE_CNT increments on each CPU_EN=1 and saturates at 8'hFF (no wrap).
- Prescaler width = $clog2 of the largest RATE_DIV.

Optional Feature:
- Macro: CPU_STEP_BREAKPOINT_EN.
- Defined:
  - Adds ports BP_ADDR in 4 and BP_VALID in 1.
  - In RUN, when BP_VALID && PC==BP_ADDR at terminal count, go to IDLE with no pulse; the PC stays at the breakpoint.
  - The next step event executes that instruction normally.
  - halt_hit takes priority over the breakpoint.
- Undefined: ports absent; no breakpoint logic.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_HALT=2'd2;
  - OPC_JMP=4'hF;
  - rate-select width.
- One natural sub-module: key_debouncer (synchronizer, stability counter, press-pulse output; parameter DEBOUNCE_CYCLES). Instantiated once.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, RATE_DIV_0=8, RATE_DIV_1=4, RATE_DIV_2=2, RATE_DIV_3=1.
- Reset: RESET=1 for 2 cycles with RUN_SW=1 -> STATE=0, CPU_EN=0, CYCLE_CNT=0; RUN entered on the first cycle after release.
- Debounce: STEP_KEY_N low for 3 cycles then high (bounce) -> no CPU_EN; low held for 6 cycles -> exactly one CPU_EN pulse; CYCLE_CNT=1; release -> no pulse.
- Run rate: RUN_SW=1, RATE_SEL=0 for 40 cycles -> CPU_EN every 8th cycle (5 pulses); RATE_SEL=3 -> CPU_EN continuously high; RUN_SW=0 -> CPU_EN=0 next cycle, STATE=0.
- Halt: RUN, RATE_SEL=1, PC=4'h6, INSTR=8'hF6 -> at terminal count no pulse, STATE=2, HALTED=1; step presses and RUN_SW toggles ignored; RESET clears to IDLE.
- Saturation: RATE_SEL=3 for 300 cycles -> CYCLE_CNT=8'hFF and holds.
- Breakpoint (CPU_STEP_BREAKPOINT_EN): BP_VALID=1, BP_ADDR=4'h3, PC reaching 3 -> STATE=0 without pulse; one step press -> one CPU_EN.
